// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, fixed XLEN-cycle latency for every op and operand value.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in_1,
    input  logic [XLEN-1:0] in_2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              dz_q, dz_d;
    logic              ovf_q, ovf_d;
    logic [XLEN-1:0]   out_q, out_d;

    logic              sgn_1, sgn_2;
    logic [XLEN-1:0]   mag_1, mag_2;
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0] step, prod_fix;
    logic [XLEN-1:0]   quo, rem, quo_s, rem_s, result;

    always_comb begin : operand_prep
        sgn_1 = in_1[XLEN-1] & (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6);
        sgn_2 = in_2[XLEN-1] & (op == 3'd1 || op == 3'd4 || op == 3'd6);
        mag_1 = sgn_1 ? -in_1 : in_1;
        mag_2 = sgn_2 ? -in_2 : in_2;
    end

    // prod_q holds {partial product, multiplier} or {partial remainder, quotient}
    always_comb begin : datapath
        mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        diff    = rem_sh - {1'b0, opnd_q};
        if (!op_q[2]) begin
            step = {mul_sum, prod_q[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            step = {diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end else begin
            step = {rem_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        end
        prod_fix = neg_q ? -step : step;
        quo      = step[XLEN-1:0];
        rem      = step[2*XLEN-1:XLEN];
        quo_s    = neg_q ? -quo : quo;
        rem_s    = rneg_q ? -rem : rem;
        // A zero divisor leaves the dividend magnitude as remainder, so REM/REMU need no override
        if (!op_q[2]) begin
            result = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (!op_q[1]) begin
            result = dz_q ? '1 : (ovf_q ? MOST_NEG : quo_s);
        end else begin
            result = ovf_q ? '0 : rem_s;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        out_d   = out_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    op_d    = op;
                    opnd_d  = op[2] ? mag_2 : mag_1;
                    prod_d  = {{XLEN{1'b0}}, (op[2] ? mag_1 : mag_2)};
                    neg_d   = sgn_1 ^ sgn_2;
                    rneg_d  = sgn_1;
                    dz_d    = op[2] && (in_2 == '0);
                    ovf_d   = (op == 3'd4 || op == 3'd6) && (in_1 == MOST_NEG) && (in_2 == '1);
                end
            end
            CALC: begin
                prod_d = step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    out_d   = result;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
        end
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign out  = out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32 and XLEN=8: issue tasks queue
// expected results and completion cycles, negedge monitors pop and compare.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] val;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start32 = 1'b0;
    logic [2:0]  op32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [31:0] out32;
    logic        start8 = 1'b0;
    logic [2:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [7:0]  out8;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .in_1(a32), .in_2(b32),
        .busy(busy32), .done(done32), .out(out32)
    );

    muldiv_unit #(.XLEN(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .in_1(a8), .in_2(b8),
        .busy(busy8), .done(done8), .out(out8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL spurious_done32: got done=1 at cycle %0d expected done=0", cyc);
            end else begin
                e32 = q32.pop_front();
                check({e32.name, ".out"}, out32, e32.val);
                check({e32.name, ".lat"}, 32'(cyc), 32'(e32.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL spurious_done8: got done=1 at cycle %0d expected done=0", cyc);
            end else begin
                e8 = q8.pop_front();
                check({e8.name, ".out"}, {24'b0, out8}, e8.val);
                check({e8.name, ".lat"}, 32'(cyc), 32'(e8.cyc));
            end
        end
    end

    task automatic applyStimulus32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] exp, input string nm);
        exp_t e;
        @(negedge clk);
        start32 = 1'b1;
        op32    = o;
        a32     = a;
        b32     = b;
        e.val   = exp;
        e.cyc   = cyc + 1 + 32;
        e.name  = nm;
        q32.push_back(e);
        @(negedge clk);
        start32 = 1'b0;
        op32    = 3'($urandom);
        a32     = $urandom;
        b32     = $urandom;
    endtask

    task automatic applyStimulus8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] exp, input string nm);
        exp_t e;
        @(negedge clk);
        start8 = 1'b1;
        op8    = o;
        a8     = a;
        b8     = b;
        e.val  = {24'b0, exp};
        e.cyc  = cyc + 1 + 8;
        e.name = nm;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        op8    = 3'($urandom);
        a8     = 8'($urandom);
        b8     = 8'($urandom);
    endtask

    task automatic checkOutput32();
        int n = 0;
        while (q32.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q32.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout32: got %0d pending results expected 0", q32.size());
            q32.delete();
        end
    endtask

    task automatic checkOutput8();
        int n = 0;
        while (q8.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout8: got %0d pending results expected 0", q8.size());
            q8.delete();
        end
    endtask

    initial begin
        #1;
        check("reset.busy", {31'b0, busy32}, 32'd0);
        check("reset.done", {31'b0, done32}, 32'd0);
        check("reset.out", out32, 32'd0);
        check("reset.out8", {24'b0, out8}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        applyStimulus32(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
        checkOutput32();
        applyStimulus32(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
        checkOutput32();
        applyStimulus32(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        checkOutput32();
        applyStimulus32(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
        checkOutput32();
        applyStimulus32(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div");
        checkOutput32();
        applyStimulus32(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem");
        checkOutput32();
        applyStimulus32(3'd5, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, "divu");
        checkOutput32();
        applyStimulus32(3'd7, 32'hFFFFFFF9, 32'd2, 32'd1, "remu");
        checkOutput32();
        applyStimulus32(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_by0");
        checkOutput32();
        applyStimulus32(3'd6, 32'd5, 32'd0, 32'd5, "rem_by0");
        checkOutput32();
        applyStimulus32(3'd4, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, "div_by0");
        checkOutput32();
        applyStimulus32(3'd7, 32'h12345678, 32'd0, 32'h12345678, "remu_by0");
        checkOutput32();
        applyStimulus32(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        checkOutput32();
        applyStimulus32(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_ovf");
        checkOutput32();

        // a start pulse during CALC must not restart or queue anything
        applyStimulus32(3'd5, 32'd100, 32'd7, 32'd14, "ignored_start");
        repeat (4) @(negedge clk);
        check("calc.busy", {31'b0, busy32}, 32'd1);
        check("calc.done", {31'b0, done32}, 32'd0);
        repeat (5) @(negedge clk);
        start32 = 1'b1;
        op32    = 3'd0;
        a32     = 32'd2;
        b32     = 32'd3;
        @(negedge clk);
        start32 = 1'b0;
        checkOutput32();
        repeat (40) @(negedge clk);
        check("hold.out", out32, 32'd14);
        check("hold.busy", {31'b0, busy32}, 32'd0);

        // start held high: a new op every 33 cycles, operands changed between accepts
        begin
            exp_t e;
            int   a_edge;
            @(negedge clk);
            start32 = 1'b1;
            op32    = 3'd0;
            a32     = 32'd3;
            b32     = 32'd5;
            a_edge  = cyc + 1;
            e.val = 32'd15; e.cyc = a_edge + 32; e.name = "b2b0"; q32.push_back(e);
            e.val = 32'd1;  e.cyc = a_edge + 65; e.name = "b2b1"; q32.push_back(e);
            e.val = 32'd2;  e.cyc = a_edge + 98; e.name = "b2b2"; q32.push_back(e);
            for (int k = 0; k < 98; k++) begin
                @(negedge clk);
                check($sformatf("b2b.busy%0d", k), {31'b0, busy32}, ((k % 33) == 32) ? 32'd0 : 32'd1);
                if (k == 0) begin
                    op32 = 3'd3;
                    a32  = 32'hFFFFFFFF;
                    b32  = 32'd2;
                end else if (k == 33) begin
                    op32 = 3'd7;
                    a32  = 32'd100;
                    b32  = 32'd7;
                end else if (k == 66) begin
                    start32 = 1'b0;
                end
            end
            checkOutput32();
        end

        // reset at iteration 15 aborts the op and clears the outputs
        applyStimulus32(3'd0, 32'h1234, 32'h10, 32'h0, "aborted");
        repeat (15) @(negedge clk);
        #2;
        rst = 1'b1;
        q32.delete();
        #1;
        check("abort.busy", {31'b0, busy32}, 32'd0);
        check("abort.done", {31'b0, done32}, 32'd0);
        check("abort.out", out32, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort.out_held", out32, 32'd0);
        applyStimulus32(3'd0, 32'h1234, 32'h10, 32'h12340, "after_reset");
        checkOutput32();

        applyStimulus8(3'd1, 8'h80, 8'h7F, 8'hC0, "mulh8");
        checkOutput8();
        applyStimulus8(3'd4, 8'h81, 8'h03, 8'hD6, "div8");
        checkOutput8();
        applyStimulus8(3'd6, 8'h81, 8'h03, 8'hFF, "rem8");
        checkOutput8();
        applyStimulus8(3'd3, 8'hFF, 8'hFF, 8'hFE, "mulhu8");
        checkOutput8();
        check("idle.busy8", {31'b0, busy8}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
